// File: rtl/mux_2to1_if.sv
// mux_2to1_if: data, select and registered-result bundle for mux_2to1
interface mux_2to1_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] a0, a1, q;
  logic s;
  modport master (output a0, a1, s, input q);
  modport slave (input a0, a1, s, output q);
endinterface

// File: rtl/mux_2to1.sv
// mux_2to1: parameterised 2-to-1 word mux with a registered output
module mux_2to1 #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst_n,
  mux_2to1_if.slave bus
);
  logic [WIDTH-1:0] q_q, q_d;
  // bitwise ternary keeps bits where a0 and a1 agree even when s is X
  always_comb q_d = bus.s ? bus.a1 : bus.a0;
  always_ff @(posedge clk)
    if (!rst_n) q_q <= '0;
    else q_q <= q_d;
  assign bus.q = q_q;
endmodule

// File: tb/tb_mux_2to1.sv
// tb_mux_2to1: directed and random checks of mux_2to1 at WIDTH 1, 8 and 32
module tb_mux_2to1;
  logic clk, rst_n, s;
  logic [63:0] a0, a1, e1, e8, e32;
  int checks = 0, errors = 0;
  mux_2to1_if #(.WIDTH(1)) b1();
  mux_2to1_if #(.WIDTH(8)) b8();
  mux_2to1_if #(.WIDTH(32)) b32();
  assign b1.a0 = a0[0:0];
  assign b1.a1 = a1[0:0];
  assign b1.s = s;
  assign b8.a0 = a0[7:0];
  assign b8.a1 = a1[7:0];
  assign b8.s = s;
  assign b32.a0 = a0[31:0];
  assign b32.a1 = a1[31:0];
  assign b32.s = s;
  mux_2to1 #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mux_2to1 #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  mux_2to1 #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // reference: the word chosen by s, weighted arithmetically, truncated to w bits
  function automatic logic [63:0] model(int w);
    logic [63:0] m;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (!rst_n) return '0;
    if ($isunknown(s)) return a0 & m;
    return (a0 * (64'd1 - {63'd0, s}) + a1 * {63'd0, s}) & m;
  endfunction
  task automatic check(string tag);
    checks++;
    assert (b1.q === e1[0:0]) else begin errors++; $error("FAIL %s w1 q=%h expected %h", tag, b1.q, e1[0:0]); end
    checks++;
    assert (b8.q === e8[7:0]) else begin errors++; $error("FAIL %s w8 q=%h expected %h", tag, b8.q, e8[7:0]); end
    checks++;
    assert (b32.q === e32[31:0]) else begin errors++; $error("FAIL %s w32 q=%h expected %h", tag, b32.q, e32[31:0]); end
  endtask
  task automatic cycle(string tag);
    @(posedge clk);
    e1 = model(1);
    e8 = model(8);
    e32 = model(32);
    @(negedge clk);
    check(tag);
  endtask
  initial begin
    rst_n = 1'b0; s = 1'b0; a0 = 64'h09; a1 = 64'hB6;
    @(negedge clk);
    cycle("reset_first");
    cycle("reset_hold");
    rst_n = 1'b1;
    cycle("sel_a0");
    cycle("sel_a0_stable");
    s = 1'b1;
    #2 check("no_comb_path");
    cycle("sel_a1");
    s = 1'b0; a0 = 64'hFF;
    cycle("simultaneous");
    a0 = 64'h00; a1 = 64'hFF;
    for (int i = 0; i < 6; i++) begin
      s = ~s;
      cycle("toggle");
    end
    a1 = 64'hB6; s = 1'b1;
    cycle("pre_mid_reset");
    rst_n = 1'b0;
    cycle("mid_reset");
    rst_n = 1'b1;
    cycle("reset_release");
    a0 = 64'h5555_5555; a1 = 64'hAAAA_AAAA; s = 1'b0;
    cycle("sweep_a0");
    s = 1'b1;
    cycle("sweep_a1");
    a0 = 64'h1234_5678_9ABC_DEF0; a1 = a0; s = 1'bx;
    cycle("x_select_agree");
    for (int i = 0; i < 200; i++) begin
      rst_n = ($urandom_range(15) != 0);
      s = $urandom_range(1);
      a0 = {$urandom, $urandom};
      a1 = {$urandom, $urandom};
      cycle("random");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
